// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches, buffers returned
// words in order with their PC, and flushes buffered/in-flight work on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned   AW         = $clog2(DEPTH);
  localparam int unsigned   CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [31:0]   RESET_PC_A = {RESET_PC[31:2], 2'b00};

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];

  logic [CW:0] used;
  logic        req_fire, push, pop, has_head;

  assign used           = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = !reset && !redirect_valid && (used < {1'b0, DEPTH_C});
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && !redirect_valid && (discard_q == '0);
  assign has_head       = !reset && (count_q != '0);
  assign instr_valid    = has_head && !redirect_valid;
  assign instr          = has_head ? fifo_data_q[rd_q] : '0;
  assign instr_pc       = has_head ? fifo_pc_q[rd_q] : '0;
  assign pop            = instr_valid && instr_ready;

  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_d       = rd_q;
    wr_d       = wr_q;

    unique case ({req_fire, imem_rsp_valid})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: ;
    endcase

    if (redirect_valid) begin
      pc_d      = {redirect_pc[31:2], 2'b00};
      rsp_pc_d  = {redirect_pc[31:2], 2'b00};
      count_d   = '0;
      rd_d      = '0;
      wr_d      = '0;
      // inflight already counts earlier stale requests, so after dropping this
      // cycle's response every remaining outstanding request is stale.
      discard_d = inflight_d;
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) begin
        wr_d     = wr_q + AW'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) rd_d = rd_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC_A;
      rsp_pc_q   <= RESET_PC_A;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_pc_q[wr_q]   <= rsp_pc_q;
      fifo_data_q[wr_q] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop && (count_q == DEPTH_C)));
      assert (!(imem_rsp_valid && (inflight_q == '0)));
      assert (discard_q <= inflight_q);
      assert (used <= {1'b0, DEPTH_C});
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (RESET_PC=0, DEPTH=2) with a fixed-latency
// in-order instruction memory model and logs of accepted requests/deliveries.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          mcyc = 0;
  int          lat  = 1;
  logic [31:0] req_log[$];
  logic [31:0] dpc_log[$];
  logic [31:0] dins_log[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  // Memory: responses presented at the falling edge, handshakes sampled just after.
  always @(negedge clk) begin
    mcyc = mcyc + 1;
    if (reset) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else if (mq.size() > 0 && mq[0].due <= mcyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].addr ^ K;
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (!reset && imem_req_valid && imem_req_ready) begin
      mq.push_back('{imem_req_addr, mcyc + lat});
      req_log.push_back(imem_req_addr);
    end
    if (!reset && instr_valid && instr_ready) begin
      dpc_log.push_back(instr_pc);
      dins_log.push_back(instr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input logic rdy);
    tick();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    lat            = l;
    instr_ready    = rdy;
    imem_req_ready = 1'b1;
    tick();
    reset = 1'b0;
    req_log.delete();
    dpc_log.delete();
    dins_log.delete();
  endtask

  task automatic wait_deliv(input int n, input int budget, output bit ok);
    int c = 0;
    while (dpc_log.size() < n && c < budget) begin
      tick();
      c++;
    end
    ok = (dpc_log.size() >= n);
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got=%0b exp=0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_instr_valid got=%0b exp=0", instr_valid); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instr); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%0b exp=1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL first_req_addr got=%h exp=0", imem_req_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL first_instr_valid got=%0b exp=0", instr_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset(1, 1'b1);
    tick();
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_c1_valid got=%0b exp=0", instr_valid); end
    tick();
    #1;
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stream_c2_valid got=%0b exp=1", instr_valid); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL stream_c2_pc got=%h exp=0", instr_pc); end
    checks++; if (instr !== K) begin failures++; $display("FAIL stream_c2_instr got=%h exp=%h", instr, K); end
    repeat (16) tick();
    checks++; if (dpc_log.size() < 4) begin failures++; $display("FAIL stream_count got=%0d exp>=4", dpc_log.size()); end
    if (dpc_log.size() >= 4 && req_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        e = 32'(4 * i);
        checks++; if (req_log[i] !== e) begin failures++; $display("FAIL stream_req[%0d] got=%h exp=%h", i, req_log[i], e); end
        checks++; if (dpc_log[i] !== e) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, dpc_log[i], e); end
        checks++; if (dins_log[i] !== (e ^ K)) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, dins_log[i], e ^ K); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1, 1'b0);
    repeat (8) tick();
    #1;
    checks++; if (req_log.size() != 2) begin failures++; $display("FAIL bp_req_count got=%0d exp=2", req_log.size()); end
    if (req_log.size() >= 2) begin
      checks++; if (req_log[1] !== 32'h4) begin failures++; $display("FAIL bp_req1 got=%h exp=4", req_log[1]); end
    end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%0b exp=0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL bp_head got=%0b/%h exp=1/0", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    #1;
    checks++; if (instr_pc !== 32'h4) begin failures++; $display("FAIL bp_pop_pc got=%h exp=4", instr_pc); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin failures++; $display("FAIL bp_refill got=%0b/%h exp=1/8", imem_req_valid, imem_req_addr); end
    repeat (4) tick();
    #1;
    checks++; if (req_log.size() != 3) begin failures++; $display("FAIL bp_req_count2 got=%0d exp=3", req_log.size()); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid2 got=%0b exp=0", imem_req_valid); end
    checks++; if (instr_pc !== 32'h4) begin failures++; $display("FAIL bp_head2 got=%h exp=4", instr_pc); end
  endtask

  task automatic test_redirect_stale();
    bit ok;
    do_reset(3, 1'b1);
    repeat (7) tick();
    checks++; if (req_log.size() != 4) begin failures++; $display("FAIL stale_setup_reqs got=%0d exp=4", req_log.size()); end
    checks++; if (dpc_log.size() != 2) begin failures++; $display("FAIL stale_setup_deliv got=%0d exp=2", dpc_log.size()); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stale_redir_req got=%0b exp=0", imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    wait_deliv(3, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stale_timeout got=%0d exp=3", dpc_log.size()); end
    if (ok) begin
      checks++; if (dpc_log[2] !== 32'h100) begin failures++; $display("FAIL stale_pc got=%h exp=100", dpc_log[2]); end
      checks++; if (dins_log[2] !== (32'h100 ^ K)) begin failures++; $display("FAIL stale_instr got=%h exp=%h", dins_log[2], 32'h100 ^ K); end
      checks++; if (req_log[4] !== 32'h100) begin failures++; $display("FAIL stale_req got=%h exp=100", req_log[4]); end
    end
  endtask

  task automatic test_redirect_align();
    bit ok;
    do_reset(1, 1'b1);
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin failures++; $display("FAIL align_req got=%0b/%h exp=1/200", imem_req_valid, imem_req_addr); end
    wait_deliv(2, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL align_timeout got=%0d exp=2", dpc_log.size()); end
    if (ok) begin
      checks++; if (dpc_log[0] !== 32'h0) begin failures++; $display("FAIL align_pc0 got=%h exp=0", dpc_log[0]); end
      checks++; if (dpc_log[1] !== 32'h200) begin failures++; $display("FAIL align_pc1 got=%h exp=200", dpc_log[1]); end
      checks++; if (dins_log[1] !== (32'h200 ^ K)) begin failures++; $display("FAIL align_instr got=%h exp=%h", dins_log[1], 32'h200 ^ K); end
    end
  endtask

  task automatic test_redirect_with_rsp();
    bit ok;
    do_reset(1, 1'b0);
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rsp_redir_valid got=%0b exp=0", instr_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rsp_flushed got=%0b exp=0", instr_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin failures++; $display("FAIL rsp_req got=%0b/%h exp=1/300", imem_req_valid, imem_req_addr); end
    instr_ready = 1'b1;
    wait_deliv(1, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rsp_timeout got=%0d exp=1", dpc_log.size()); end
    if (ok) begin
      checks++; if (dpc_log[0] !== 32'h300) begin failures++; $display("FAIL rsp_pc got=%h exp=300", dpc_log[0]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset(3, 1'b1);
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_pc = 32'h80;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL b2b_req got=%0b exp=0", imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    wait_deliv(1, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=%0d exp=1", dpc_log.size()); end
    if (ok) begin
      checks++; if (dpc_log[0] !== 32'h80) begin failures++; $display("FAIL b2b_pc got=%h exp=80", dpc_log[0]); end
      checks++; if (dins_log[0] !== (32'h80 ^ K)) begin failures++; $display("FAIL b2b_instr got=%h exp=%h", dins_log[0], 32'h80 ^ K); end
      checks++; if (req_log[2] !== 32'h80) begin failures++; $display("FAIL b2b_req_addr got=%h exp=80", req_log[2]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_outs got=%0b/%0b exp=0/0", imem_req_valid, instr_valid); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin failures++; $display("FAIL mid_rst_data got=%h/%h exp=0/0", instr, instr_pc); end
    tick();
    reset = 1'b0;
    req_log.delete();
    dpc_log.delete();
    dins_log.delete();
    instr_ready = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL mid_after_valid got=%0b exp=0", instr_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL mid_after_req got=%0b/%h exp=1/0", imem_req_valid, imem_req_addr); end
    tick();
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin failures++; $display("FAIL mid_credit got=%0b/%h exp=1/4", imem_req_valid, imem_req_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_align();
    test_redirect_with_rsp();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
